// File: rtl/ic_ne_bvashr_seq_checker.sv
// Multi-cycle bvashr-disequality invertibility checker: scans a W-bit word CHUNK bits per cycle.
// Optional early exit, enabled by defining IC_NE_BVASHR_EARLY_EXIT_EN.
module ic_ne_bvashr_seq_checker #(
    parameter int unsigned W     = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ic,
    output logic         out_all0,
    output logic         out_all1
);
    localparam int unsigned N  = W / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (W < 2 || CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_bad_param
            $error("ic_ne_bvashr_seq_checker: illegal W/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_sreg;
    logic [W-1:0]   w_sreg_shr;
    logic [CW-1:0]  r_cnt;
    logic           r_seen0;
    logic           r_seen1;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_out_ic;
    logic           r_out_all0;
    logic           r_out_all1;
    logic [CHUNK-1:0] w_chunk;
    logic           w_seen0_upd;
    logic           w_seen1_upd;
    logic           w_accept;
    logic           w_last;
    logic           w_res_seen0;
    logic           w_res_seen1;
    logic           w_in_ready_nxt;
    logic           w_out_valid_nxt;
    logic           w_out_ic_nxt;
    logic           w_out_all0_nxt;
    logic           w_out_all1_nxt;

    assign w_chunk     = r_sreg[CHUNK-1:0];
    assign w_seen0_upd = r_seen0 | ~(&w_chunk);
    assign w_seen1_upd = r_seen1 | (|w_chunk);
    assign w_accept    = in_valid & r_in_ready;
    assign w_last      = (r_cnt == CW'(N - 1));

    // Zero-filled right shift; a single-chunk word simply empties.
    generate
        if (CHUNK == W) begin : g_shr_all
            assign w_sreg_shr = '0;
        end else begin : g_shr_part
            assign w_sreg_shr = {{CHUNK{1'b0}}, r_sreg[W-1:CHUNK]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_SCAN;
            S_SCAN: begin
`ifdef IC_NE_BVASHR_EARLY_EXIT_EN
                if (w_last || (w_seen0_upd && w_seen1_upd)) w_state_nxt = S_DONE;
`else
                if (w_last) w_state_nxt = S_DONE;
`endif
            end
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; result uses the freshly updated flags on the final scan edge.
    always_comb begin
        w_res_seen0     = (r_state == S_SCAN) ? w_seen0_upd : r_seen0;
        w_res_seen1     = (r_state == S_SCAN) ? w_seen1_upd : r_seen1;
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_out_ic_nxt    = 1'b0;
        w_out_all0_nxt  = 1'b0;
        w_out_all1_nxt  = 1'b0;
        if (w_state_nxt == S_DONE) begin
            w_out_ic_nxt   = w_res_seen0 & w_res_seen1;
            w_out_all0_nxt = ~w_res_seen1;
            w_out_all1_nxt = ~w_res_seen0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_ic    <= 1'b0;
            r_out_all0  <= 1'b0;
            r_out_all1  <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_ic    <= w_out_ic_nxt;
            r_out_all0  <= w_out_all0_nxt;
            r_out_all1  <= w_out_all1_nxt;
        end
    end

    // Scan datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_seen0 <= 1'b0;
            r_seen1 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sreg  <= in_data;
                        r_cnt   <= '0;
                        r_seen0 <= 1'b0;
                        r_seen1 <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_sreg  <= w_sreg_shr;
                    r_cnt   <= r_cnt + CW'(1);
                    r_seen0 <= w_seen0_upd;
                    r_seen1 <= w_seen1_upd;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ic    = r_out_ic;
    assign out_all0  = r_out_all0;
    assign out_all1  = r_out_all1;

endmodule

// File: tb/tb_ic_ne_bvashr_seq_checker.sv
// Bench for ic_ne_bvashr_seq_checker: W=8/CHUNK=2 table + sequences, W=16 sweeps at CHUNK=16 and CHUNK=1.
module tb_ic_ne_bvashr_seq_checker;
`ifdef IC_NE_BVASHR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8 = 1'b0;
    logic [7:0] d8  = '0;
    logic       or8 = 1'b1;
    logic       ir8, ov8, ic8, a08, a18;

    logic        iv16 = 1'b0;
    logic [15:0] d16  = '0;
    logic        or16 = 1'b1;
    logic        ira, ova, ica, a0a, a1a;
    logic        irb, ovb, icb, a0b, a1b;

    int total = 0;
    int bad   = 0;

    ic_ne_bvashr_seq_checker #(.W(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(d8),
        .out_valid(ov8), .out_ready(or8), .out_ic(ic8), .out_all0(a08), .out_all1(a18));

    ic_ne_bvashr_seq_checker #(.W(16), .CHUNK(16)) u_dut16a (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ira), .in_data(d16),
        .out_valid(ova), .out_ready(or16), .out_ic(ica), .out_all0(a0a), .out_all1(a1a));

    ic_ne_bvashr_seq_checker #(.W(16), .CHUNK(1)) u_dut16b (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(irb), .in_data(d16),
        .out_valid(ovb), .out_ready(or16), .out_ic(icb), .out_all0(a0b), .out_all1(a1b));

    typedef struct {
        logic [7:0] data;
        logic [2:0] flags;   // {ic, all0, all1}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference class: mixed iff neither all zeros nor all ones.
    function automatic logic [2:0] ref_flags(input logic [15:0] x, input int w);
        logic [15:0] mask;
        logic        z, o;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        z = ((x & mask) == 16'h0000);
        o = ((x & mask) == mask);
        return {!z && !o, z, o};
    endfunction

    // Reference latency: N chunks, or with early exit the first chunk count whose prefix holds both bit values.
    function automatic int ref_lat(input logic [15:0] x, input int w, input int c);
        bit s0 = 0, s1 = 0;
        for (int i = 0; i < w; i++) begin
            if (x[i]) s1 = 1; else s0 = 1;
            if (EARLY && ((i + 1) % c == 0) && s0 && s1) return (i + 1) / c;
        end
        return w / c;
    endfunction

    task automatic run8(input logic [7:0] x, input logic [2:0] exp_flags, input string tag);
        int lat;
        d8  = x;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        d8  = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 50) begin
            chk({tag, "_busy_ready"}, 32'(ir8), 32'd0);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(16'(x), 8, 2)));
        chk({tag, "_flags"}, 32'({ic8, a08, a18}), 32'(exp_flags));
        tick();
        chk({tag, "_valid_drop"}, 32'(ov8), 32'd0);
        chk({tag, "_ready_back"}, 32'(ir8), 32'd1);
        chk({tag, "_flags_zero"}, 32'({ic8, a08, a18}), 32'd0);
    endtask

    task automatic run16(input logic [15:0] x);
        bit gota = 0, gotb = 0;
        int lata = 0, latb = 0;
        logic [2:0] fa = '0, fb = '0;
        d16  = x;
        iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        for (int cyc = 1; cyc <= 40 && !(gota && gotb); cyc++) begin
            tick();
            if (!gota && ova) begin gota = 1; lata = cyc; fa = {ica, a0a, a1a}; end
            if (!gotb && ovb) begin gotb = 1; latb = cyc; fb = {icb, a0b, a1b}; end
        end
        tick();
        chk("c16_seen", 32'(gota), 32'd1);
        chk("c16_latency", 32'(lata), 32'(ref_lat(x, 16, 16)));
        chk("c16_flags", 32'(fa), 32'(ref_flags(x, 16)));
        chk("c1_seen", 32'(gotb), 32'd1);
        chk("c1_latency", 32'(latb), 32'(ref_lat(x, 16, 1)));
        chk("c1_flags", 32'(fb), 32'(ref_flags(x, 16)));
        chk("w16_idle", 32'({ira, irb, ova, ovb}), 32'b1100);
    endtask

    initial begin
        vec_t tbl[6];
        int   n;
        logic [7:0]  r8;
        logic [15:0] r16;

        tbl[0] = '{8'h00, 3'b010};
        tbl[1] = '{8'hFF, 3'b001};
        tbl[2] = '{8'h80, 3'b100};
        tbl[3] = '{8'h02, 3'b100};
        tbl[4] = '{8'h01, 3'b100};
        tbl[5] = '{8'h7F, 3'b100};

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_flags", 32'({ic8, a08, a18}), 32'd0);
        chk("rst_w16", 32'({ira, irb, ova, ovb}), 32'b1100);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) run8(tbl[i].data, tbl[i].flags, $sformatf("tbl%0d", i));

        // Backpressure on a mixed result; a stray input pulse must be ignored.
        or8 = 1'b0;
        d8  = 8'h01;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin tick(); n++; end
        chk("bp_latency", 32'(n), 32'(ref_lat(16'h0001, 8, 2)));
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin iv8 = 1'b1; d8 = 8'hFF; end
            else iv8 = 1'b0;
            chk("bp_valid_hold", 32'(ov8), 32'd1);
            chk("bp_flags_hold", 32'({ic8, a08, a18}), 32'b100);
            chk("bp_ready_low", 32'(ir8), 32'd0);
            tick();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        chk("bp_release_valid", 32'(ov8), 32'd0);
        chk("bp_release_ready", 32'(ir8), 32'd1);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (ov8) n++;
            tick();
        end
        chk("bp_stray_ignored", 32'(n), 32'd0);

        // Reset in the 2nd scan cycle of 0x0F discards the operation.
        d8  = 8'h0F;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_valid", 32'(ov8), 32'd0);
        chk("abort_ready", 32'(ir8), 32'd1);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ov8) n++;
        end
        chk("abort_no_result", 32'(n), 32'd0);
        run8(8'h00, 3'b010, "post_abort");

        // Random 8-bit words against the reference class.
        for (int i = 0; i < 30; i++) begin
            r8 = (i % 10 == 0) ? 8'h00 : (i % 10 == 1) ? 8'hFF : 8'($urandom);
            run8(r8, ref_flags(16'(r8), 8), $sformatf("rnd8_%0d", i));
        end

        // W=16 sweep at CHUNK=16 and CHUNK=1.
        for (int i = 0; i < 30; i++) begin
            r16 = (i % 8 == 0) ? 16'h0000 : (i % 8 == 1) ? 16'hFFFF :
                  (i % 8 == 2) ? 16'h8000 : 16'($urandom);
            run16(r16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
